// File: rtl/mem_request_queue.sv
// In-order memory request queue: buffers core loads/stores, issues at most one per cycle
// through a registered issue stage, and returns load data one cycle after the read strobe.
module mem_request_queue #(
  parameter int          CORE         = 0,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned ADDRESS_BITS = 20,
  parameter int unsigned DEPTH_BITS   = 2
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    req_valid,
  input  logic                    req_write,
  input  logic [ADDRESS_BITS-1:0] req_address,
  input  logic [DATA_WIDTH-1:0]   req_data,
  output logic                    req_ready,
  input  logic                    stall,
  output logic                    read,
  output logic                    write,
  output logic [ADDRESS_BITS-1:0] read_address,
  output logic [ADDRESS_BITS-1:0] write_address,
  output logic [DATA_WIDTH-1:0]   in_data,
  input  logic [DATA_WIDTH-1:0]   mem_data,
  output logic                    resp_valid,
  output logic [ADDRESS_BITS-1:0] resp_address,
  output logic [DATA_WIDTH-1:0]   resp_data,
  output logic [DEPTH_BITS:0]     count
);

  localparam int unsigned Depth = 1 << DEPTH_BITS;
  localparam logic [DEPTH_BITS:0]   FullCount = {1'b1, {DEPTH_BITS{1'b0}}};
  localparam logic [DEPTH_BITS:0]   CountOne  = {{DEPTH_BITS{1'b0}}, 1'b1};
  localparam logic [DEPTH_BITS-1:0] PtrOne    = {{(DEPTH_BITS-1){1'b0}}, 1'b1};

  // Core index is informational only.
  logic unused_core;
  assign unused_core = ^CORE;

  // Queue storage, indexed by head/tail pointers.
  logic                    ent_write_q   [Depth];
  logic [ADDRESS_BITS-1:0] ent_address_q [Depth];
  logic [DATA_WIDTH-1:0]   ent_data_q    [Depth];

  logic [DEPTH_BITS-1:0] head_q, head_d;
  logic [DEPTH_BITS-1:0] tail_q, tail_d;
  logic [DEPTH_BITS:0]   count_q, count_d;

  logic                    read_q, write_q;
  logic [ADDRESS_BITS-1:0] read_address_q, write_address_q;
  logic [DATA_WIDTH-1:0]   in_data_q;

  logic                    resp_valid_q;
  logic [ADDRESS_BITS-1:0] resp_address_q;
  logic [DATA_WIDTH-1:0]   resp_data_q;

  logic push, issue;

  // Handshake decode and next-state for pointers and occupancy.
  always_comb begin
    req_ready = (count_q < FullCount);
    push      = req_valid & req_ready;
    // Issue uses pre-edge occupancy, so a request pushed this edge cannot bypass.
    issue     = ~stall & (count_q != '0);
    head_d    = issue ? head_q + PtrOne : head_q;
    tail_d    = push ? tail_q + PtrOne : tail_q;
    count_d   = count_q;
    if (push && !issue) begin
      count_d = count_q + CountOne;
    end else if (!push && issue) begin
      count_d = count_q - CountOne;
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clock) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage write at the tail; contents need no reset since occupancy gates use.
  always_ff @(posedge clock) begin
    if (push) begin
      ent_write_q[tail_q]   <= req_write;
      ent_address_q[tail_q] <= req_address;
      ent_data_q[tail_q]    <= req_data;
    end
  end

  // Registered issue stage: one strobe per issued entry, unused fields forced to zero.
  always_ff @(posedge clock) begin
    if (!reset || !issue) begin
      read_q          <= 1'b0;
      write_q         <= 1'b0;
      read_address_q  <= '0;
      write_address_q <= '0;
      in_data_q       <= '0;
    end else begin
      read_q          <= ~ent_write_q[head_q];
      write_q         <= ent_write_q[head_q];
      read_address_q  <= ent_write_q[head_q] ? '0 : ent_address_q[head_q];
      write_address_q <= ent_write_q[head_q] ? ent_address_q[head_q] : '0;
      in_data_q       <= ent_write_q[head_q] ? ent_data_q[head_q] : '0;
    end
  end

  // Load response: capture memory data during the read cycle.
  always_ff @(posedge clock) begin
    if (!reset) begin
      resp_valid_q   <= 1'b0;
      resp_address_q <= '0;
      resp_data_q    <= '0;
    end else begin
      resp_valid_q   <= read_q;
      resp_address_q <= read_q ? read_address_q : '0;
      resp_data_q    <= read_q ? mem_data : '0;
    end
  end

  assign read          = read_q;
  assign write         = write_q;
  assign read_address  = read_address_q;
  assign write_address = write_address_q;
  assign in_data       = in_data_q;
  assign resp_valid    = resp_valid_q;
  assign resp_address  = resp_address_q;
  assign resp_data     = resp_data_q;
  assign count         = count_q;

endmodule

// File: tb/tb_mem_request_queue.sv
// Self-checking bench for mem_request_queue: queue-based reference model checked every cycle,
// a table of directed vectors, hand-written corner sequences and a randomized phase.
module tb_mem_request_queue;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid, req_write;
  logic [19:0] req_address;
  logic [31:0] req_data;
  logic        req_ready;
  logic        stall;
  logic        read, write;
  logic [19:0] read_address, write_address;
  logic [31:0] in_data, mem_data;
  logic        resp_valid;
  logic [19:0] resp_address;
  logic [31:0] resp_data;
  logic [2:0]  count;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  mem_request_queue #(
    .CORE(0), .DATA_WIDTH(32), .ADDRESS_BITS(20), .DEPTH_BITS(2)
  ) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_write(req_write), .req_address(req_address),
    .req_data(req_data), .req_ready(req_ready), .stall(stall),
    .read(read), .write(write), .read_address(read_address), .write_address(write_address),
    .in_data(in_data), .mem_data(mem_data),
    .resp_valid(resp_valid), .resp_address(resp_address), .resp_data(resp_data),
    .count(count)
  );

  // Memory contents as a pure function of address.
  function automatic logic [31:0] mem_fn(input logic [19:0] a);
    if (a == 20'h00010) return 32'hDEADBEEF;
    return {a[15:0], ~a[15:0]};
  endfunction

  assign mem_data = read ? mem_fn(read_address) : 32'h0;

  // Reference model: a queue of pending requests plus expected output values.
  typedef struct packed {
    logic        w;
    logic [19:0] a;
    logic [31:0] d;
  } ent_t;

  ent_t        mq[$];
  logic        m_read, m_write, m_rv;
  logic [19:0] m_raddr, m_waddr, m_ra;
  logic [31:0] m_wdata, m_rd;

  task automatic model_edge();
    ent_t e;
    bit   iss, psh;
    if (!reset) begin
      mq.delete();
      m_read = 0; m_write = 0; m_raddr = 0; m_waddr = 0; m_wdata = 0;
      m_rv = 0; m_ra = 0; m_rd = 0;
    end else begin
      iss = !stall && (mq.size() > 0);
      psh = req_valid && (mq.size() < 4);
      m_rv = m_read;
      m_ra = m_read ? m_raddr : 20'h0;
      m_rd = m_read ? mem_fn(m_raddr) : 32'h0;
      m_read = 0; m_write = 0; m_raddr = 0; m_waddr = 0; m_wdata = 0;
      if (iss) begin
        e = mq.pop_front();
        if (e.w) begin
          m_write = 1; m_waddr = e.a; m_wdata = e.d;
        end else begin
          m_read = 1; m_raddr = e.a;
        end
      end
      if (psh) mq.push_back('{w: req_write, a: req_address, d: req_data});
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("req_ready", 32'(req_ready), 32'(mq.size() < 4));
    chk("count", 32'(count), 32'(mq.size()));
    chk("read", 32'(read), 32'(m_read));
    chk("write", 32'(write), 32'(m_write));
    chk("rw_exclusive", 32'(read & write), 32'h0);
    chk("read_address", 32'(read_address), 32'(m_raddr));
    chk("write_address", 32'(write_address), 32'(m_waddr));
    chk("in_data", in_data, m_wdata);
    chk("resp_valid", 32'(resp_valid), 32'(m_rv));
    if (m_rv) begin
      chk("resp_address", 32'(resp_address), 32'(m_ra));
      chk("resp_data", resp_data, m_rd);
    end
  endtask

  // Advance one edge, update the model, sample 1 time unit after the edge.
  task automatic step();
    @(posedge clock);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic drive(input logic v, input logic w, input logic [19:0] a,
                       input logic [31:0] d, input logic s);
    req_valid = v; req_write = w; req_address = a; req_data = d; stall = s;
  endtask

  typedef struct {
    logic        valid, wr;
    logic [19:0] addr;
    logic        stall;
    logic        exp_ready;
    logic [2:0]  exp_count;
    logic        exp_read, exp_write;
    logic [19:0] exp_raddr;
    logic        exp_rv;
    logic [31:0] exp_rdata;
  } vec_t;

  function automatic vec_t mk(input logic v, input logic [19:0] a, input logic s,
                              input logic rdy, input logic [2:0] c, input logic rd,
                              input logic [19:0] ra, input logic rv, input logic [31:0] rdat);
    vec_t t;
    t.valid = v; t.wr = 1'b0; t.addr = a; t.stall = s; t.exp_ready = rdy; t.exp_count = c;
    t.exp_read = rd; t.exp_write = 1'b0; t.exp_raddr = ra; t.exp_rv = rv; t.exp_rdata = rdat;
    return t;
  endfunction

  vec_t      tbl[14];
  logic [19:0] got[$];

  initial begin
    // Single load, then fill-and-refuse under stall, then full with push+issue and drain.
    tbl[0]  = mk(1, 20'h00010, 0, 1, 1, 0, 20'h0,   0, 32'h0);
    tbl[1]  = mk(0, 20'h0,     0, 1, 0, 1, 20'h10,  0, 32'h0);
    tbl[2]  = mk(0, 20'h0,     0, 1, 0, 0, 20'h0,   1, 32'hDEADBEEF);
    tbl[3]  = mk(1, 20'h00100, 1, 1, 1, 0, 20'h0,   0, 32'h0);
    tbl[4]  = mk(1, 20'h00101, 1, 1, 2, 0, 20'h0,   0, 32'h0);
    tbl[5]  = mk(1, 20'h00102, 1, 1, 3, 0, 20'h0,   0, 32'h0);
    tbl[6]  = mk(1, 20'h00103, 1, 0, 4, 0, 20'h0,   0, 32'h0);
    tbl[7]  = mk(1, 20'h00104, 1, 0, 4, 0, 20'h0,   0, 32'h0);
    tbl[8]  = mk(1, 20'h00105, 0, 1, 3, 1, 20'h100, 0, 32'h0);
    tbl[9]  = mk(0, 20'h0,     0, 1, 2, 1, 20'h101, 1, mem_fn(20'h100));
    tbl[10] = mk(0, 20'h0,     0, 1, 1, 1, 20'h102, 1, mem_fn(20'h101));
    tbl[11] = mk(0, 20'h0,     0, 1, 0, 1, 20'h103, 1, mem_fn(20'h102));
    tbl[12] = mk(0, 20'h0,     0, 1, 0, 0, 20'h0,   1, mem_fn(20'h103));
    tbl[13] = mk(0, 20'h0,     0, 1, 0, 0, 20'h0,   0, 32'h0);

    reset = 1'b0;
    drive(0, 0, 20'h0, 32'h0, 0);
    step();
    step();
    chk("reset_ready", 32'(req_ready), 32'h1);
    chk("reset_count", 32'(count), 32'h0);
    reset = 1'b1;

    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].valid, tbl[i].wr, tbl[i].addr, 32'h0, tbl[i].stall);
      step();
      chk($sformatf("tbl%0d_ready", i), 32'(req_ready), 32'(tbl[i].exp_ready));
      chk($sformatf("tbl%0d_count", i), 32'(count), 32'(tbl[i].exp_count));
      chk($sformatf("tbl%0d_read", i), 32'(read), 32'(tbl[i].exp_read));
      chk($sformatf("tbl%0d_write", i), 32'(write), 32'(tbl[i].exp_write));
      chk($sformatf("tbl%0d_raddr", i), 32'(read_address), 32'(tbl[i].exp_raddr));
      chk($sformatf("tbl%0d_rvalid", i), 32'(resp_valid), 32'(tbl[i].exp_rv));
      if (tbl[i].exp_rv) chk($sformatf("tbl%0d_rdata", i), resp_data, tbl[i].exp_rdata);
    end

    // Store then load to the same address: write pulse, then read pulse next cycle.
    drive(1, 1, 20'h00020, 32'h12345678, 0);
    step();
    drive(1, 0, 20'h00020, 32'h0, 0);
    step();
    chk("st_write", 32'(write), 32'h1);
    chk("st_read", 32'(read), 32'h0);
    chk("st_waddr", 32'(write_address), 32'h20);
    chk("st_in_data", in_data, 32'h12345678);
    drive(0, 0, 20'h0, 32'h0, 0);
    step();
    chk("ld_read", 32'(read), 32'h1);
    chk("ld_write", 32'(write), 32'h0);
    chk("ld_raddr", 32'(read_address), 32'h20);
    step();
    step();

    // Wrap-around: ten loads at one push per cycle; responses in order, occupancy stays low.
    got.delete();
    for (int c = 0; c < 40 && got.size() < 10; c++) begin
      if (c < 10) drive(1, 0, 20'h00200 + 20'(c), 32'h0, 0);
      else drive(0, 0, 20'h0, 32'h0, 0);
      step();
      chk("wrap_count_max", 32'(count <= 3'd2), 32'h1);
      if (resp_valid) got.push_back(resp_address);
    end
    chk("wrap_resp_total", 32'(got.size()), 32'd10);
    for (int i = 0; i < got.size(); i++) chk($sformatf("wrap_resp%0d", i), 32'(got[i]),
                                             32'(20'h00200 + 20'(i)));

    // Reset mid-stream with three entries queued and a load in the issue stage.
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 20'h00300 + 20'(i), 32'h0, 1);
      step();
    end
    drive(1, 0, 20'h00303, 32'h0, 0);
    step();
    chk("mid_count", 32'(count), 32'h3);
    chk("mid_read", 32'(read), 32'h1);
    drive(0, 0, 20'h0, 32'h0, 0);
    reset = 1'b0;
    step();
    reset = 1'b1;
    chk("rst_read", 32'(read), 32'h0);
    chk("rst_write", 32'(write), 32'h0);
    chk("rst_resp_valid", 32'(resp_valid), 32'h0);
    chk("rst_count", 32'(count), 32'h0);
    chk("rst_ready", 32'(req_ready), 32'h1);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("rst_no_stale", 32'(resp_valid | read | write), 32'h0);
    end

    // Randomized traffic with occasional reset.
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 59) != 0);
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            20'($urandom_range(0, 63)), $urandom(), 1'($urandom_range(0, 9) < 3));
      step();
    end
    reset = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_request_queue.md
MEM_REQUEST_QUEUE -- requirements
Module: mem_request_queue

Interface
REQ-001 Parameters SHALL be:
- CORE, default 0, core index.
- DATA_WIDTH, default 32, data word width.
- ADDRESS_BITS, default 20, word address width.
- DEPTH_BITS, default 2, queue depth DEPTH = 2^DEPTH_BITS.

REQ-002 Ports SHALL be:
- clock  in  1  rising-edge clock, sole clock.
- reset  in  1  synchronous, active-low reset.
- req_valid  in  1  core request present.
- req_write  in  1  1 = store, 0 = load.
- req_address  in  ADDRESS_BITS  request address.
- req_data  in  DATA_WIDTH  store data.
- req_ready  out  1  queue can accept a request.
- stall  in  1  holds issue to memory.
- read  out  1  memory read strobe.
- write  out  1  memory write strobe.
- read_address  out  ADDRESS_BITS  memory read address.
- write_address  out  ADDRESS_BITS  memory write address.
- in_data  out  DATA_WIDTH  memory write data.
- mem_data  in  DATA_WIDTH  memory read data.
- resp_valid  out  1  load response valid.
- resp_address  out  ADDRESS_BITS  load response address.
- resp_data  out  DATA_WIDTH  load response data.
- count  out  DEPTH_BITS+1  current queue occupancy.

Function
REQ-003 Block SHALL be an in-order FIFO of DEPTH entries, each entry {write, address, data}, feeding the memory interface one operation per cycle.
REQ-004 req_ready SHALL be combinational: req_ready = (count < DEPTH).
REQ-005 A push SHALL occur on a rising edge with req_valid=1 and req_ready=1; the entry is written at the tail and the tail pointer increments modulo DEPTH.
REQ-006 An issue SHALL occur on a rising edge with stall=0 and count>0. On issue:
- the head entry loads the registered issue stage;
- the head pointer increments modulo DEPTH.
REQ-007 On each rising edge with no issue, read and write SHALL be 0 for the following cycle.
REQ-008 Issue outputs SHALL be registered:
- Issued load: read=1, write=0, read_address=entry address.
- Issued store: write=1, read=0, write_address=entry address, in_data=entry data.
- Fields not in use SHALL be 0.
REQ-009 read and write SHALL never both be 1 in the same cycle.
REQ-010 No bypass SHALL exist. A request pushed at edge N issues at edge N+1 at the earliest, with read/write asserted in the cycle after edge N+1.
REQ-011 Simultaneous push and issue SHALL both occur, with count unchanged.
- When full, push is refused regardless of a same-cycle issue.
- When empty, the incoming request is not issued in that same edge.
REQ-012 count SHALL update each edge as count + push − issue, with range 0..DEPTH.
REQ-013 Memory read data SHALL be valid in the cycle read=1. On the next rising edge, the block SHALL register:
- resp_valid = 1;
- resp_data = mem_data;
- resp_address = read_address.
resp_valid SHALL be 0 in all other cycles.
REQ-014 Stores SHALL produce no response.
REQ-015 Back-to-back loads SHALL produce back-to-back responses, one per cycle, in issue order.
REQ-016 stall=1 SHALL freeze the head pointer and deassert read/write from the next cycle; pushes continue until full.
REQ-017 Request ordering SHALL be preserved strictly: a load queued after a store to the same address issues after that store.

Reset
REQ-018 When reset=0 at a rising edge, the block SHALL:
- clear head, tail and count to 0;
- clear the issue stage to 0 (read=0, write=0, all addresses/data 0);
- clear resp_valid, resp_address and resp_data to 0.
REQ-019 Reset asserted mid-operation SHALL discard all queued entries and any pending response; no read or write SHALL be asserted in the cycle following the reset edge.
REQ-020 req_ready SHALL read 1 in the cycle after the reset edge.

Verification
REQ-021 The bench SHALL cover these directed scenarios (DEPTH_BITS=2):
- Single load: push load 0x00010 at edge 1 -> read=1, read_address=0x00010 after edge 2; with mem_data=0xDEADBEEF, resp_valid=1, resp_data=0xDEADBEEF, resp_address=0x00010 after edge 3.
- Store then load: push store 0x00020/0x12345678, then load 0x00020 -> write pulse with in_data=0x12345678 precedes read pulse by exactly one cycle; read never coincides with write.
- Fill and refuse: stall=1, push 5 requests -> count=4, req_ready=0, 5th request not accepted. Then stall=0 -> 4 issues on 4 consecutive cycles in push order, and count returns to 0.
- Full with simultaneous push/issue: count=4, stall=0, req_valid=1 -> push refused, count=3 after the edge.
- Wrap-around: 10 loads at one push per cycle, stall=0 -> 10 responses with addresses in order, count never exceeds 2.
- Reset mid-stream: reset=0 with count=3 and a load issued -> following cycle read=0, write=0, resp_valid=0, count=0, req_ready=1; no stale responses afterwards.
